// File: rtl/dec_pkg.sv
// Shared constants and helpers for the decoder / priority-encoder pair.
package dec_pkg;

  localparam int DEC_N = 4;
  localparam int DEC_W = $clog2(DEC_N);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } enc_state_t;

  function automatic logic [DEC_N-1:0] onehot(input logic [DEC_W-1:0] idx);
    return DEC_N'(1) << idx;
  endfunction

endpackage

// File: rtl/pri_encoder_q_lsb_pick.sv
// Combinational search for the first set bit of vec, starting at start and
// wrapping modulo N (N is a power of two, so the W-bit sum wraps naturally).
module lsb_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = |vec;
    // Walk offsets from farthest to nearest so the nearest set bit wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (vec[start + W'(k)]) idx = start + W'(k);
    end
  end

endmodule

// File: rtl/pri_encoder_q.sv
// Sequential N-to-log2(N) priority encoder with valid/ready output.
// Define PRI_ENCODER_Q_ROUND_ROBIN_EN for rotating priority; default is fixed (bit 0 highest).
//
// state   | meaning
// ST_IDLE | no undelivered index, valid=0
// ST_HOLD | y holds an undelivered index, valid=1
module pri_encoder_q
  import dec_pkg::*;
#(
  parameter int N = DEC_N,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         e,
  input  logic [N-1:0] a,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] y,
  output logic [N-1:0] pending
);

  enc_state_t   state_q, state_d;
  logic [W-1:0] y_q, y_d;
  logic [N-1:0] pending_q, pending_d;

  logic [N-1:0] cand;
  logic         slot_free;
  logic [W-1:0] pick_idx;
  logic         pick_found;
  logic [W-1:0] pick_start;
  logic [N-1:0] pick_mask;

  assign cand      = pending_q | (e ? a : '0);
  assign slot_free = (state_q == ST_IDLE) || ready;
  assign pick_mask = {{(N-1){1'b0}}, 1'b1} << pick_idx;

`ifdef PRI_ENCODER_Q_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;

  assign pick_start = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (slot_free && pick_found) ptr_d = pick_idx + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign pick_start = '0;
`endif

  lsb_pick #(
    .N(N),
    .W(W)
  ) u_lsb_pick (
    .vec  (cand),
    .start(pick_start),
    .idx  (pick_idx),
    .found(pick_found)
  );

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    pending_d = cand;
    if (slot_free) begin
      if (pick_found) begin
        state_d   = ST_HOLD;
        y_d       = pick_idx;
        pending_d = cand & ~pick_mask;
      end else begin
        state_d   = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      y_q       <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      pending_q <= pending_d;
    end
  end

  assign valid   = (state_q == ST_HOLD);
  assign y       = y_q;
  assign pending = pending_q;

endmodule
